// File: rtl/lpif_ll_pkg.sv
// Shared definitions for the LPIF logic-link receive path:
// flit layout offsets and the receive credit FSM states.
package lpif_ll_pkg;

    localparam int LPIF_LL_FLIT_W = 77;

    localparam int STATE_LSB  = 0;
    localparam int PROTID_LSB = 4;
    localparam int DATA_LSB   = 6;
    localparam int DVALID_LSB = 70;
    localparam int CRC_LSB    = 71;
    localparam int CRCV_LSB   = 75;
    localparam int VALID_LSB  = 76;

    typedef enum logic [1:0] {
        LL_OFFLINE,
        LL_CREDIT_INIT,
        LL_ONLINE
    } ll_rx_state_e;

endpackage

// File: rtl/lpif_ll_sync_fifo.sv
// Single-clock show-ahead FIFO with synchronous clear; the caller
// only issues push/pop when they are legal for the current count.
module lpif_ll_sync_fifo #(
    parameter int WIDTH = 77,
    parameter int DEPTH = 8,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/lpif_ll_rx_credit_fifo.sv
// Receive flit buffer for the LPIF slave: show-ahead FIFO, initial
// credit advertisement after link-up, and one credit back per pop.
module lpif_ll_rx_credit_fifo
    import lpif_ll_pkg::*;
#(
    parameter int WIDTH = LPIF_LL_FLIT_W,
    parameter int DEPTH = 8,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk_wr,
    input  logic             rst_wr_n,
    input  logic             rx_online,
    input  logic             rxfifo_push,
    input  logic [WIDTH-1:0] rxfifo_push_data,
    output logic [WIDTH-1:0] rxfifo_downstream_data,
    output logic             rxfifo_downstream_valid,
    input  logic             rxfifo_downstream_ready,
    output logic             tx_credit_return,
    output logic             rx_init_done,
    output logic [CW-1:0]    rx_fifo_count,
    output logic             rx_overflow_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL      = CW'(DEPTH);
    localparam logic [AW-1:0] INIT_LAST = AW'(DEPTH - 1);

    ll_rx_state_e     state_q;
    ll_rx_state_e     state_d;
    logic [AW-1:0]    init_cnt_q;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] data_q;
    logic [CW-1:0]    count;
    logic             online;
    logic             init_credit;
    logic             valid;
    logic             pop;
    logic             push_ok;
    logic             credit_q;
    logic             err_q;

    always_ff @(posedge clk_wr) begin
        if (!rst_wr_n) begin
            state_q <= LL_OFFLINE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!rx_online) begin
            state_d = LL_OFFLINE;
        end else begin
            unique case (state_q)
                LL_OFFLINE:     state_d = LL_CREDIT_INIT;
                LL_CREDIT_INIT: begin
                    if (init_cnt_q == INIT_LAST) begin
                        state_d = LL_ONLINE;
                    end
                end
                LL_ONLINE:      state_d = LL_ONLINE;
                default:        state_d = LL_OFFLINE;
            endcase
        end
    end

    always_comb begin
        online      = 1'b0;
        init_credit = 1'b0;
        unique case (state_q)
            LL_CREDIT_INIT: init_credit = 1'b1;
            LL_ONLINE:      online      = 1'b1;
            default:        ;
        endcase
    end

    // One advertised credit per cycle spent in CREDIT_INIT
    always_ff @(posedge clk_wr) begin
        if (!rst_wr_n || !rx_online || state_q != LL_CREDIT_INIT) begin
            init_cnt_q <= '0;
        end else begin
            init_cnt_q <= init_cnt_q + 1'b1;
        end
    end

    assign valid   = online && (count != '0);
    assign pop     = valid && rxfifo_downstream_ready;
    assign push_ok = online && rxfifo_push && ((count != FULL) || pop);

    lpif_ll_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk_wr),
        .rst_n     (rst_wr_n),
        .clr       (!rx_online),
        .push      (push_ok),
        .push_data (rxfifo_push_data),
        .pop       (pop),
        .head_data (head),
        .count     (count)
    );

    // Overflow flag survives link drops; only reset clears it
    always_ff @(posedge clk_wr) begin
        if (!rst_wr_n) begin
            credit_q <= 1'b0;
            err_q    <= 1'b0;
            data_q   <= '0;
        end else begin
            credit_q <= pop && rx_online;
            err_q    <= err_q || (rxfifo_push && !push_ok);
            data_q   <= rxfifo_downstream_data;
        end
    end

    assign rxfifo_downstream_data  = valid ? head : data_q;
    assign rxfifo_downstream_valid = valid;
    assign tx_credit_return        = init_credit || credit_q;
    assign rx_init_done            = online;
    assign rx_fifo_count           = count;
    assign rx_overflow_err         = err_q;

endmodule

// File: tb/tb_lpif_ll_rx_credit_fifo.sv
// Bench for the LPIF receive credit FIFO: directed phases then random
// traffic, all checked against a queue-based model every cycle.
module tb_lpif_ll_rx_credit_fifo;

    localparam int WIDTH = 77;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             online;
    logic             push;
    logic [WIDTH-1:0] pdata;
    logic             ready;
    logic [WIDTH-1:0] ds_data;
    logic             ds_valid;
    logic             credit;
    logic             init_done;
    logic [CW-1:0]    fcount;
    logic             ovf;

    int checks   = 0;
    int failures = 0;

    int               m_mode;
    int               m_left;
    logic [WIDTH-1:0] q[$];
    bit               m_err;
    bit               m_credit;
    logic [WIDTH-1:0] m_last;
    int               credits_seen;

    always #5 clk = ~clk;

    lpif_ll_rx_credit_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk_wr                  (clk),
        .rst_wr_n                (rst_n),
        .rx_online               (online),
        .rxfifo_push             (push),
        .rxfifo_push_data        (pdata),
        .rxfifo_downstream_data  (ds_data),
        .rxfifo_downstream_valid (ds_valid),
        .rxfifo_downstream_ready (ready),
        .tx_credit_return        (credit),
        .rx_init_done            (init_done),
        .rx_fifo_count           (fcount),
        .rx_overflow_err         (ovf)
    );

    function automatic bit exp_valid();
        return (m_mode == 2) && (q.size() != 0);
    endfunction

    function automatic logic [WIDTH-1:0] exp_data();
        return exp_valid() ? q[0] : m_last;
    endfunction

    function automatic logic [WIDTH-1:0] rnd_flit();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[WIDTH-1:0];
    endfunction

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model: 0=offline, 1=advertising initial credits, 2=online
    task automatic model_step();
        bit                pop_now;
        bit                room;
        logic [WIDTH-1:0]  head;
        if (!rst_n) begin
            m_mode   = 0;
            m_left   = 0;
            q.delete();
            m_err    = 0;
            m_credit = 0;
            m_last   = '0;
            return;
        end
        pop_now = exp_valid() && ready;
        head    = exp_data();
        room    = (q.size() < DEPTH) || pop_now;
        m_last  = head;
        if (push && !(m_mode == 2 && room)) m_err = 1;
        if (!online) begin
            m_mode   = 0;
            q.delete();
            m_credit = 0;
        end else begin
            m_credit = pop_now;
            if (pop_now) void'(q.pop_front());
            if (push && m_mode == 2 && room) q.push_back(pdata);
            if (m_mode == 0) begin
                m_mode = 1;
                m_left = DEPTH;
            end else if (m_mode == 1) begin
                m_left--;
                if (m_left == 0) m_mode = 2;
            end
        end
    endtask

    task automatic compare();
        chk("valid", WIDTH'(ds_valid), WIDTH'(exp_valid()));
        chk("data", ds_data, exp_data());
        chk("credit", WIDTH'(credit), WIDTH'(m_mode == 1 || m_credit));
        chk("init_done", WIDTH'(init_done), WIDTH'(m_mode == 2));
        chk("count", WIDTH'(fcount), WIDTH'(q.size()));
        chk("overflow", WIDTH'(ovf), WIDTH'(m_err));
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        if (credit) credits_seen++;
        compare();
    endtask

    task automatic idle(input int n);
        push  = 1'b0;
        ready = 1'b0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic push1(input logic [WIDTH-1:0] d, input logic rd);
        push  = 1'b1;
        pdata = d;
        ready = rd;
        cyc();
        push  = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] base;
        rst_n  = 1'b0;
        online = 1'b0;
        push   = 1'b0;
        pdata  = '0;
        ready  = 1'b0;
        credits_seen = 0;
        #1;
        idle(2);
        rst_n = 1'b1;
        idle(2);

        // Link up: DEPTH initial credits, then init_done
        online = 1'b1;
        credits_seen = 0;
        idle(DEPTH + 3);
        chk("init_credits", WIDTH'(credits_seen), WIDTH'(DEPTH));

        // Four flits held, then drained in order
        push1(77'h1_2345_6789_ABCD_EF00_0, 1'b0);
        for (int i = 1; i < 4; i++) push1(rnd_flit(), 1'b0);
        credits_seen = 0;
        ready = 1'b1;
        for (int i = 0; i < 6; i++) cyc();
        chk("drain_credits", WIDTH'(credits_seen), WIDTH'(4));

        // Overflow: ninth flit dropped
        for (int i = 0; i < DEPTH + 1; i++) push1(rnd_flit(), 1'b0);
        chk("ovf_count", WIDTH'(fcount), WIDTH'(DEPTH));
        ready = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) cyc();

        // Reset clears the flag, then full-FIFO streaming across wrap
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(DEPTH + 2);
        base = 77'h100;
        for (int i = 0; i < DEPTH; i++) push1(base + WIDTH'(i), 1'b0);
        for (int i = 0; i < 20; i++) push1(base + WIDTH'(DEPTH + i), 1'b1);
        chk("stream_count", WIDTH'(fcount), WIDTH'(DEPTH));
        chk("stream_err", WIDTH'(ovf), WIDTH'(0));

        // Drop the link with five flits stored
        ready = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        idle(1);
        online = 1'b0;
        idle(1);
        chk("drop_count", WIDTH'(fcount), WIDTH'(0));
        online = 1'b1;
        idle(DEPTH + 2);

        // Push during credit init, then reset mid-init
        push1(rnd_flit(), 1'b0);
        idle(3);
        online = 1'b0;
        idle(1);
        online = 1'b1;
        idle(2);
        push1(rnd_flit(), 1'b0);
        chk("init_push_err", WIDTH'(ovf), WIDTH'(1));
        idle(2);
        rst_n = 1'b0;
        idle(1);
        chk("rst_credit", WIDTH'(credit), WIDTH'(0));
        rst_n = 1'b1;
        idle(DEPTH + 2);

        // Random traffic with occasional link drops
        for (int i = 0; i < 600; i++) begin
            push   = ($urandom_range(99) < 55);
            pdata  = rnd_flit();
            ready  = ($urandom_range(99) < 50);
            online = ($urandom_range(99) < 2) ? 1'b0 : 1'b1;
            cyc();
        end
        push = 1'b0;
        ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
